// File: rtl/a0_uart_tx.sv
// a0_uart_tx: watches the CPU a0 register, queues each new value in a small
// word FIFO and sends every word as four 8N1 UART bytes, least significant
// byte first, on a single tx line.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high; pops the head word as soon as the FIFO is non-empty
//   START  | start bit (tx=0) for CLKS_PER_BIT cycles
//   DATA   | eight data bits of the current byte, LSB first
//   STOP   | stop bit (tx=1); next byte of the word or back to IDLE
module a0_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   a0,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [31:0]   prev_q, prev_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   mem [FIFO_DEPTH];

  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [31:0]   head;
  logic [2:0]    bit_next;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign push     = en & (a0 != prev_q);
  assign pop      = (state_q == S_IDLE) & (count != '0);
  assign full     = (count == FULL);
  // A full FIFO still accepts a word when the FSM frees a slot on the same edge.
  assign push_ok  = push & (~full | pop);
  assign head     = mem[rd_ptr_q[AW-1:0]];
  assign bit_next = bit_q + 3'd1;

  // Capture tracking, FIFO pointers and sticky overflow.
  always_comb begin
    prev_d     = en ? a0 : prev_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= a0;
    end
  end

  // Transmit FSM next state; tx_d is the line level for the following cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = head;
          byte_d  = 2'd0;
          baud_d  = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[bit_q];
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_next;
            tx_d  = shift_q[bit_next];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'h00, shift_q[31:8]};
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register; synchronous reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      shift_q    <= 32'd0;
      tx_q       <= 1'b1;
      prev_q     <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) | (count != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count;

endmodule

// File: doc/a0_uart_tx.md
Name: a0_uart_tx

Overview:
- Consumer side of the CPU's `a0` output port.
- Watches `a0` and captures each new value into a small word FIFO.
- Serialises each captured word as four 8N1 UART bytes on a single `tx` line, so program results can be read on a host terminal.
- Sits at the top level beside `cpu`, clocked by the same `clk`.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (min 2); 16 for simulation, set per board baud in synthesis.
- FIFO_DEPTH, 4, number of 32-bit words buffered (power of 2, ≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- a0  input  32  CPU register x10 value.
- en  input  1  capture enable; when 0, `a0` changes are ignored and the previous-value register is not updated.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high while FIFO non-empty or a frame is in progress.
- overflow  output  1  sticky; set when a word is dropped because the FIFO is full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued, excluding the word being transmitted.

Behaviour:
- Reset (rst=0 at edge):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - prev_a0=0, FSM=IDLE, all counters 0.
  - Reset mid-frame aborts immediately; tx returns high on that edge and the FIFO contents are discarded.
- Capture:
  - push = en & (a0 != prev_a0), evaluated combinationally.
  - On each edge with en=1, prev_a0 <= a0, whether or not the push was accepted.
  - Consequence: a0 changing to nonzero from the reset value 0 triggers a push; a0 staying 0 never does.
- FIFO:
  - Circular buffer with wrapping read/write pointers; count = write - read.
  - pop = FSM in IDLE & count != 0.
  - Push when count==FIFO_DEPTH and no pop on the same edge: word dropped, overflow <= 1. overflow clears only on reset.
  - Push and pop on the same edge: both take effect; count unchanged; a full FIFO accepts the push.
- FSM states: IDLE, START, DATA, STOP. Counters: baud counter 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..3.
  - IDLE:
    - tx=1.
    - If count != 0: pop the head word into the 32-bit shift register, byte index=0, go to START; tx=0 from this edge.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = current byte bit[bit index], LSB first, each bit held CLKS_PER_BIT cycles.
    - After bit 7, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - If byte index < 3: increment byte index, select the next byte, go straight to START (no idle gap).
    - If byte index = 3: go to IDLE.
- Byte order: little-endian, a0[7:0] first and a0[31:24] last.
- Frame length: 40*CLKS_PER_BIT cycles per word.
  - Back-to-back words are separated by exactly one IDLE cycle at tx=1.
- Latency: a0 changes before edge N → pushed at edge N → popped at edge N+1 with tx falling at N+1.
  - Requires an empty FIFO and FSM in IDLE.
- tx is a registered output with no combinational path from a0.
- busy = (state != IDLE) | (count != 0).

Test Plan:
- CLKS_PER_BIT=4, en=1, a0 0→0x000000A5 held:
  - tx falls 1 edge after the change.
  - Frame bits 0,1,0,1,0,0,1,0,1,1, then 3 zero bytes (each 0,00000000,1).
  - 160 cycles total; busy drops after the 4th stop bit; no further frames.
- a0=0x12345678:
  - Decoded bytes in order 0x78, 0x56, 0x34, 0x12.
  - Exactly 4 start bits observed with no gap between frames.
- Five distinct a0 values on consecutive cycles, FIFO_DEPTH=4:
  - First value popped on the next edge; remaining 4 queued, fifo_count=4, overflow=0.
  - Sixth distinct value while full: dropped, overflow=1.
  - Exactly 5 words emitted in push order, each separated by a 1-cycle idle.
- en=0 while a0 toggles 0x1→0x2→0x1:
  - No push, tx stays 1.
  - Raising en with a0=0x1 and prev_a0 still 0 → one word 0x00000001 sent.
- Full FIFO (count=4) with a push arriving on the same edge the FSM pops:
  - Push accepted, count stays 4, overflow stays 0.
- rst=0 asserted during DATA of byte 2:
  - tx=1, busy=0, fifo_count=0 after that edge.
  - After release with a0 unchanged and nonzero, a0 != prev_a0 (0) → the word is re-sent from byte 0.
